// File: rtl/fib_seq_gen_pkg.sv
// Shared types and constants for the additive-recurrence generator.
package fib_seq_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OP   = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [1:0] MODE_FIB  = 2'b00;
    localparam logic [1:0] MODE_LUC  = 2'b01;
    localparam logic [1:0] MODE_CUST = 2'b10;

    localparam int FIB_S0 = 0;
    localparam int FIB_S1 = 1;
    localparam int LUC_S0 = 2;
    localparam int LUC_S1 = 1;

endpackage

// File: rtl/fib_seq_gen_if.sv
// Request/result bundle for fib_seq_gen; master issues jobs, slave is the generator.
interface fib_seq_gen_if #(
    parameter int DW = 20,
    parameter int IW = 5
);
    logic          start;
    logic [1:0]    mode;
    logic [IW-1:0] i;
    logic [DW-1:0] seed0;
    logic [DW-1:0] seed1;
    logic          ready;
    logic          done_tick;
    logic          ovf;
    logic [DW-1:0] f;

    modport master (
        output start, mode, i, seed0, seed1,
        input  ready, done_tick, ovf, f
    );

    modport slave (
        input  start, mode, i, seed0, seed1,
        output ready, done_tick, ovf, f
    );
endinterface

// File: rtl/fib_seq_gen_add.sv
// DW-bit adder with carry-out; FIB_SEQ_GEN_SAT_EN clamps the sum to all-ones on carry.
module fib_seq_gen_add #(
    parameter int DW = 20
) (
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    output logic [DW-1:0] o_sum,
    output logic          o_carry
);
    logic [DW:0] w_full;

    assign w_full  = {1'b0, i_a} + {1'b0, i_b};
    assign o_carry = w_full[DW];

`ifdef FIB_SEQ_GEN_SAT_EN
    assign o_sum = w_full[DW] ? {DW{1'b1}} : w_full[DW-1:0];
`else
    assign o_sum = w_full[DW-1:0];
`endif

endmodule

// File: rtl/fib_seq_gen.sv
// FSMD computing t(i) of t(n)=t(n-1)+t(n-2) with selectable seeds.
// Optional macro FIB_SEQ_GEN_SAT_EN selects saturating instead of wrapping sums.
module fib_seq_gen
    import fib_seq_gen_pkg::*;
#(
    parameter int DW = 20,
    parameter int IW = 5
) (
    input  logic              clk,
    input  logic              reset,
    fib_seq_gen_if.slave      bus
);
    state_t        r_state, w_state_next;
    logic [DW-1:0] r_t0, w_t0_next;
    logic [DW-1:0] r_t1, w_t1_next;
    logic [IW-1:0] r_n, w_n_next;
    logic          r_ovf, w_ovf_next;
    logic [DW-1:0] w_sum;
    logic          w_carry;
    logic          w_ready;
    logic          w_done_tick;

    fib_seq_gen_add #(.DW(DW)) u_add (
        .i_a     (r_t1),
        .i_b     (r_t0),
        .o_sum   (w_sum),
        .o_carry (w_carry)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_t0    <= '0;
            r_t1    <= '0;
            r_n     <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_t0    <= w_t0_next;
            r_t1    <= w_t1_next;
            r_n     <= w_n_next;
            r_ovf   <= w_ovf_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_t0_next    = r_t0;
        w_t1_next    = r_t1;
        w_n_next     = r_n;
        w_ovf_next   = r_ovf;
        w_ready      = 1'b0;
        w_done_tick  = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready = 1'b1;
                if (bus.start) begin
                    case (bus.mode)
                        MODE_LUC: begin
                            w_t0_next = DW'(LUC_S0);
                            w_t1_next = DW'(LUC_S1);
                        end
                        MODE_CUST: begin
                            w_t0_next = bus.seed0;
                            w_t1_next = bus.seed1;
                        end
                        default: begin
                            w_t0_next = DW'(FIB_S0);
                            w_t1_next = DW'(FIB_S1);
                        end
                    endcase
                    w_n_next     = bus.i;
                    w_ovf_next   = 1'b0;
                    w_state_next = OP;
                end
            end
            OP: begin
                if (r_n == '0) begin
                    w_t1_next    = r_t0;
                    w_state_next = DONE;
                end else if (r_n == IW'(1)) begin
                    w_state_next = DONE;
                end else begin
                    // Overflow flag is sticky for the whole job.
                    w_t1_next  = w_sum;
                    w_t0_next  = r_t1;
                    w_n_next   = r_n - IW'(1);
                    w_ovf_next = r_ovf | w_carry;
                end
            end
            DONE: begin
                w_done_tick  = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign bus.ready     = w_ready;
    assign bus.done_tick = w_done_tick;
    assign bus.f         = r_t1;
    assign bus.ovf       = r_ovf;

endmodule

// File: tb/tb_fib_seq_gen.sv
// Directed, table-driven bench for fib_seq_gen plus handshake and reset sequences.
module tb_fib_seq_gen;
    localparam int DW = 20;
    localparam int IW = 5;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    fib_seq_gen_if #(.DW(DW), .IW(IW)) bus ();

    fib_seq_gen #(.DW(DW), .IW(IW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    mode;
        logic [IW-1:0] idx;
        logic [DW-1:0] s0;
        logic [DW-1:0] s1;
        logic [DW-1:0] exp_f;
        logic          exp_ovf;
        int            exp_lat;
        string         name;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic wait_ready(input string name);
        int t = 0;
        while (bus.ready !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (bus.ready !== 1'b1) chk({name, "_ready_timeout"}, 32'(bus.ready), 32'd1);
    endtask

    // One job; scramble drives junk inputs and a busy start right after acceptance.
    task automatic run_vec(input vec_t v, input bit scramble);
        int cyc;
        int extra;
        wait_ready(v.name);
        bus.mode  = v.mode;
        bus.i     = v.idx;
        bus.seed0 = v.s0;
        bus.seed1 = v.s1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1;
        chk({v.name, "_busy_ready"}, 32'(bus.ready), 32'd0);
        if (scramble) begin
            bus.mode  = 2'b01;
            bus.i     = 5'd2;
            bus.seed0 = 20'd99;
            bus.seed1 = 20'd77;
            bus.start = 1'b1;
        end
        while (bus.done_tick !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            bus.start = 1'b0;
            cyc++;
        end
        chk({v.name, "_lat"}, 32'(cyc - 1), 32'(v.exp_lat));
        chk({v.name, "_f"}, 32'(bus.f), 32'(v.exp_f));
        chk({v.name, "_ovf"}, 32'(bus.ovf), 32'(v.exp_ovf));
        @(negedge clk);
        chk({v.name, "_idle_ready"}, 32'(bus.ready), 32'd1);
        chk({v.name, "_hold_f"}, 32'(bus.f), 32'(v.exp_f));
        extra = 0;
        for (int k = 0; k < 5; k++) begin
            if (bus.done_tick === 1'b1) extra++;
            @(negedge clk);
        end
        chk({v.name, "_extra_done"}, 32'(extra), 32'd0);
    endtask

    initial begin
        int   cyc;
        int   rdy_cnt;
        int   dcnt;
        vec_t v;

        vecs[0]  = '{2'b00, 5'd10, 20'd0, 20'd0, 20'd55,  1'b0, 10, "fib10"};
        vecs[1]  = '{2'b00, 5'd0,  20'd0, 20'd0, 20'd0,   1'b0, 1,  "fib0"};
        vecs[2]  = '{2'b00, 5'd1,  20'd0, 20'd0, 20'd1,   1'b0, 1,  "fib1"};
        vecs[3]  = '{2'b01, 5'd10, 20'd0, 20'd0, 20'd123, 1'b0, 10, "luc10"};
        vecs[4]  = '{2'b01, 5'd0,  20'd0, 20'd0, 20'd2,   1'b0, 1,  "luc0"};
        vecs[5]  = '{2'b01, 5'd1,  20'd0, 20'd0, 20'd1,   1'b0, 1,  "luc1"};
        vecs[6]  = '{2'b10, 5'd3,  20'd3, 20'd4, 20'd11,  1'b0, 3,  "cust3"};
        vecs[7]  = '{2'b11, 5'd10, 20'd7, 20'd9, 20'd55,  1'b0, 10, "mode3"};
        vecs[8]  = '{2'b00, 5'd30, 20'd0, 20'd0, 20'd832040, 1'b0, 30, "fib30"};
`ifdef FIB_SEQ_GEN_SAT_EN
        vecs[9]  = '{2'b00, 5'd31, 20'd0, 20'd0, 20'hFFFFF, 1'b1, 31, "fib31"};
`else
        vecs[9]  = '{2'b00, 5'd31, 20'd0, 20'd0, 20'd297693, 1'b1, 31, "fib31"};
`endif
        vecs[10] = '{2'b10, 5'd2,  20'd0, 20'd0, 20'd0,   1'b0, 2,  "cust_zero"};

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.mode  = 2'b00;
        bus.i     = '0;
        bus.seed0 = '0;
        bus.seed1 = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_f", 32'(bus.f), 32'd0);
        chk("rst_ready", 32'(bus.ready), 32'd1);
        chk("rst_done", 32'(bus.done_tick), 32'd0);
        chk("rst_ovf", 32'(bus.ovf), 32'd0);

        for (int n = 0; n < NV; n++) begin
            run_vec(vecs[n], 1'b0);
            $display("job %s mode=%0d i=%0d f=%0d ovf=%0d", vecs[n].name, vecs[n].mode,
                     vecs[n].idx, bus.f, bus.ovf);
        end

        // Inputs change and a busy start arrives during op: result unaffected.
        v = '{2'b10, 5'd3, 20'd3, 20'd4, 20'd11, 1'b0, 3, "cust_scramble"};
        run_vec(v, 1'b1);
        $display("job %s f=%0d", v.name, bus.f);

        // Start held high: back-to-back jobs with one idle cycle in between.
        wait_ready("b2b");
        bus.mode  = 2'b00;
        bus.i     = 5'd2;
        bus.start = 1'b1;
        cyc = 0;
        while (bus.done_tick !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("b2b_first_done", 32'(bus.done_tick), 32'd1);
        cyc = 0;
        rdy_cnt = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (bus.ready === 1'b1) rdy_cnt++;
        end while (bus.done_tick !== 1'b1 && cyc < 200);
        bus.start = 1'b0;
        chk("b2b_interval", 32'(cyc), 32'd4);
        chk("b2b_idle_cycles", 32'(rdy_cnt), 32'd1);
        chk("b2b_f", 32'(bus.f), 32'd1);
        $display("job b2b interval=%0d idle=%0d f=%0d", cyc, rdy_cnt, bus.f);

        // Reset three cycles into a long job aborts it silently.
        wait_ready("rstmid");
        bus.mode  = 2'b00;
        bus.i     = 5'd20;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rstmid_async_ready", 32'(bus.ready), 32'd1);
        @(negedge clk);
        chk("rstmid_f", 32'(bus.f), 32'd0);
        chk("rstmid_ready", 32'(bus.ready), 32'd1);
        chk("rstmid_ovf", 32'(bus.ovf), 32'd0);
        reset = 1'b0;
        dcnt = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (bus.done_tick === 1'b1) dcnt++;
        end
        chk("rstmid_no_done", 32'(dcnt), 32'd0);
        $display("job rstmid f=%0d done_ticks=%0d", bus.f, dcnt);
        v = '{2'b00, 5'd5, 20'd0, 20'd0, 20'd5, 1'b0, 5, "after_rst_fib5"};
        run_vec(v, 1'b0);
        $display("job %s f=%0d", v.name, bus.f);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
